otp_keypad_entry: RTL and testbench



---
 rtl/otp_pkg.sv | 31 +++
 rtl/keypad_scan.sv | 94 +++++++++
 rtl/otp_keypad_entry.sv | 118 +++++++++++
 tb/tb_otp_keypad_entry.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otp_pkg : shared widths, keypad map and scan/debounce encodings            |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package otp_pkg;

  localparam int OTP_W      = 16;
  localparam int NIB_W      = 4;
  localparam int NUM_DIGITS = 4;

  // Nibble for key index {row,col}; index 0 sits in the low nibble.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {
    FRAME_NONE  = 2'd0,
    FRAME_KEY   = 2'd1,
    FRAME_MULTI = 2'd2
  } frame_kind_e;

  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } deb_state_e;

  function automatic logic [NIB_W-1:0] key_decode(input logic [3:0] key_idx);
    return KEY_MAP[{key_idx, 2'b00} +: NIB_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scan : column synchroniser, row drive and per-frame key capture     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module keypad_scan
  import otp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic        frame_done,
  output frame_kind_e frame_kind,
  output logic [3:0]  frame_key
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row;
  logic [1:0]       r_hits;
  logic [3:0]       r_key;

  logic       w_slot_end;
  logic [3:0] w_down;
  logic [1:0] w_ndown;
  logic [1:0] w_col;
  logic [2:0] w_total;
  logic [1:0] w_nsum;
  logic [3:0] w_key;

  // Hit counts saturate at 2: beyond that only "more than one key" matters.
  always_comb begin
    w_slot_end = (r_div == DIV_LAST);
    w_down     = ~r_col_sync;
    w_ndown    = 2'd0;
    w_col      = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (w_down[c]) begin
        w_col = 2'(c);
        if (w_ndown != 2'd2) w_ndown = w_ndown + 2'd1;
      end
    end
    w_total = {1'b0, r_hits} + {1'b0, w_ndown};
    w_nsum  = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
    w_key   = ((w_ndown != 2'd0) && (r_hits == 2'd0)) ? {r_row, w_col} : r_key;
  end

  assign row_n = ~(4'b0001 << r_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_div      <= '0;
      r_row      <= 2'd0;
      r_hits     <= 2'd0;
      r_key      <= 4'd0;
      frame_done <= 1'b0;
      frame_kind <= FRAME_NONE;
      frame_key  <= 4'd0;
    end else begin
      r_col_meta <= col_n;
      r_col_sync <= r_col_meta;
      frame_done <= 1'b0;
      if (w_slot_end) begin
        r_div <= '0;
        r_row <= r_row + 2'd1;
        if (r_row == 2'd3) begin
          frame_done <= 1'b1;
          frame_key  <= w_key;
          if (w_nsum == 2'd0)      frame_kind <= FRAME_NONE;
          else if (w_nsum == 2'd1) frame_kind <= FRAME_KEY;
          else                     frame_kind <= FRAME_MULTI;
          r_hits <= 2'd0;
          r_key  <= 4'd0;
        end else begin
          r_hits <= w_nsum;
          r_key  <= w_key;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/otp_keypad_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otp_keypad_entry : debounced 4x4 keypad to 4-digit OTP entry register      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module otp_keypad_entry
  import otp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       col_n,
  input  logic             clear,
  output logic [3:0]       row_n,
  output logic [OTP_W-1:0] user_otp,
  output logic [2:0]       digit_cnt,
  output logic             otp_valid,
  output logic             key_pressed
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_CNT - 1);

  logic        w_frame_done;
  frame_kind_e w_frame_kind;
  logic [3:0]  w_frame_key;

  deb_state_e       r_state;
  frame_kind_e      r_prev_kind;
  logic [3:0]       r_prev_key;
  logic [CNT_W-1:0] r_stable_cnt;

  logic             w_same;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_stable;
  logic             w_accept;
  logic             w_release;
  logic [NIB_W-1:0] w_nib;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_n      (col_n),
    .row_n      (row_n),
    .frame_done (w_frame_done),
    .frame_kind (w_frame_kind),
    .frame_key  (w_frame_key)
  );

  // stable_cnt counts repeats, so N identical frames means a count of N-1.
  always_comb begin
    w_same     = (w_frame_kind == r_prev_kind) &&
                 ((w_frame_kind != FRAME_KEY) || (w_frame_key == r_prev_key));
    w_cnt_next = '0;
    if ((w_frame_kind != FRAME_MULTI) && w_same)
      w_cnt_next = (r_stable_cnt == CNT_MAX) ? CNT_MAX : r_stable_cnt + 1'b1;
    w_stable   = (w_cnt_next >= CNT_ACCEPT);
    w_accept   = w_frame_done && (r_state == ST_RELEASED) &&
                 (w_frame_kind == FRAME_KEY) && w_stable;
    w_release  = w_frame_done && (r_state == ST_PRESSED) &&
                 (w_frame_kind == FRAME_NONE) && w_stable;
    w_nib      = key_decode(w_frame_key);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RELEASED;
      r_prev_kind  <= FRAME_NONE;
      r_prev_key   <= 4'd0;
      r_stable_cnt <= '0;
      key_pressed  <= 1'b0;
    end else if (w_frame_done) begin
      r_prev_kind  <= w_frame_kind;
      r_prev_key   <= w_frame_key;
      r_stable_cnt <= w_cnt_next;
      case (r_state)
        ST_RELEASED: if (w_accept) begin
          r_state     <= ST_PRESSED;
          key_pressed <= 1'b1;
        end
        ST_PRESSED: if (w_release) begin
          r_state     <= ST_RELEASED;
          key_pressed <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_otp  <= '0;
      digit_cnt <= 3'd0;
      otp_valid <= 1'b0;
    end else begin
      otp_valid <= 1'b0;
      if (clear) begin
        user_otp  <= '0;
        digit_cnt <= 3'd0;
      end else if (w_accept) begin
        if (digit_cnt >= 3'(NUM_DIGITS)) begin
          user_otp  <= {{(OTP_W-NIB_W){1'b0}}, w_nib};
          digit_cnt <= 3'd1;
        end else begin
          user_otp  <= {user_otp[OTP_W-NIB_W-1:0], w_nib};
          digit_cnt <= digit_cnt + 3'd1;
          otp_valid <= (digit_cnt == 3'(NUM_DIGITS - 1));
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otp_keypad_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_otp_keypad_entry : self-checking bench with keypad matrix model         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_otp_keypad_entry;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic        clear;
  logic [3:0]  row_n;
  logic [15:0] user_otp;
  logic [2:0]  digit_cnt;
  logic        otp_valid;
  logic        key_pressed;

  logic [15:0] keys;
  int checks = 0;
  int failures = 0;

  logic [3:0] tb_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  logic [15:0] exp_otp;
  int          exp_cnt;
  int          exp_valid;

  int          valid_pulses = 0;
  int          valid_wide = 0;
  int          valid_badcnt = 0;
  int          kp_rises = 0;
  logic [15:0] last_valid_otp = 16'h0;
  logic        prev_valid = 1'b0;
  logic        prev_kp = 1'b0;

  otp_keypad_entry #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_n       (col_n),
    .clear       (clear),
    .row_n       (row_n),
    .user_otp    (user_otp),
    .digit_cnt   (digit_cnt),
    .otp_valid   (otp_valid),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // A held key at (r,c) pulls column c low while row r is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_kp    = 1'b0;
    end else begin
      if (otp_valid) begin
        valid_pulses++;
        last_valid_otp = user_otp;
        if (digit_cnt != 3'd4) valid_badcnt++;
        if (prev_valid) valid_wide++;
      end
      if (key_pressed && !prev_kp) kp_rises++;
      prev_valid = otp_valid;
      prev_kp    = key_pressed;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic model_digit(input logic [3:0] nib);
    if (exp_cnt == 4) begin
      exp_otp = {12'h000, nib};
      exp_cnt = 1;
    end else begin
      exp_otp = {exp_otp[11:0], nib};
      exp_cnt++;
      if (exp_cnt == 4) exp_valid++;
    end
  endtask

  task automatic hold_keys(input logic [15:0] mask, input int hold_f, input int rel_f);
    keys = mask;
    repeat (hold_f*FRAME) @(negedge clk);
    keys = 16'h0;
    repeat (rel_f*FRAME) @(negedge clk);
  endtask

  task automatic press_digit(input int idx, input int hold_f, input int rel_f);
    hold_keys(16'(1) << idx, hold_f, rel_f);
    model_digit(tb_map[idx]);
  endtask

  task automatic test_reset();
    for (int i = 0; i < FRAME && row_n == 4'b1110; i++) @(negedge clk);
    checks++;
    if (row_n === 4'b1110) begin
      failures++;
      $display("FAIL scan_advance: got row_n=%b expected not 1110", row_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (row_n !== 4'b1110) begin failures++; $display("FAIL rst_row_n: got %b expected 1110", row_n); end
    checks++;
    if (user_otp !== 16'h0) begin failures++; $display("FAIL rst_user_otp: got %h expected 0000", user_otp); end
    checks++;
    if (digit_cnt !== 3'd0) begin failures++; $display("FAIL rst_digit_cnt: got %0d expected 0", digit_cnt); end
    checks++;
    if (otp_valid !== 1'b0) begin failures++; $display("FAIL rst_otp_valid: got %b expected 0", otp_valid); end
    checks++;
    if (key_pressed !== 1'b0) begin failures++; $display("FAIL rst_key_pressed: got %b expected 0", key_pressed); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_otp = 16'h0;
    exp_cnt = 0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_row;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (row_n !== exp_row) begin
        failures++;
        $display("FAIL scan_row_k%0d: got %b expected %b", k, row_n, exp_row);
      end
    end
  endtask

  task automatic test_entry();
    int v0;
    int idx_list [4] = '{0, 1, 2, 3};
    v0 = valid_pulses;
    foreach (idx_list[i]) begin
      press_digit(idx_list[i], 4, 4);
      checks++;
      if (user_otp !== exp_otp || digit_cnt !== 3'(exp_cnt)) begin
        failures++;
        $display("FAIL entry_step%0d: got %h/%0d expected %h/%0d", i, user_otp, digit_cnt, exp_otp, exp_cnt);
      end
    end
    checks++;
    if (user_otp !== 16'h123A) begin failures++; $display("FAIL entry_otp: got %h expected 123a", user_otp); end
    checks++;
    if (digit_cnt !== 3'd4) begin failures++; $display("FAIL entry_cnt: got %0d expected 4", digit_cnt); end
    checks++;
    if (valid_pulses - v0 != 1) begin failures++; $display("FAIL entry_valid_count: got %0d expected 1", valid_pulses - v0); end
    checks++;
    if (last_valid_otp !== 16'h123A) begin failures++; $display("FAIL entry_valid_otp: got %h expected 123a", last_valid_otp); end
  endtask

  task automatic test_new_entry();
    int v0;
    v0 = valid_pulses;
    press_digit(8, 4, 4);
    checks++;
    if (user_otp !== 16'h0007) begin failures++; $display("FAIL new_entry_otp: got %h expected 0007", user_otp); end
    checks++;
    if (digit_cnt !== 3'd1) begin failures++; $display("FAIL new_entry_cnt: got %0d expected 1", digit_cnt); end
    checks++;
    if (valid_pulses != v0) begin failures++; $display("FAIL new_entry_valid: got %0d pulses expected 0", valid_pulses - v0); end
  endtask

  task automatic test_bounce();
    int k0;
    k0 = kp_rises;
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (FRAME) @(negedge clk);
    end
    hold_keys(16'h0020, 4, 4);
    model_digit(4'h5);
    checks++;
    if (user_otp !== 16'h0075) begin failures++; $display("FAIL bounce_otp: got %h expected 0075", user_otp); end
    checks++;
    if (digit_cnt !== 3'd2) begin failures++; $display("FAIL bounce_cnt: got %0d expected 2", digit_cnt); end
    checks++;
    if (kp_rises - k0 != 1) begin failures++; $display("FAIL bounce_key_pressed_rises: got %0d expected 1", kp_rises - k0); end
  endtask

  task automatic test_multi();
    int k0;
    k0 = kp_rises;
    hold_keys(16'h0003, 5, 4);
    checks++;
    if (user_otp !== exp_otp || digit_cnt !== 3'(exp_cnt)) begin
      failures++;
      $display("FAIL multi_no_accept: got %h/%0d expected %h/%0d", user_otp, digit_cnt, exp_otp, exp_cnt);
    end
    checks++;
    if (kp_rises != k0) begin failures++; $display("FAIL multi_key_pressed: got %0d rises expected 0", kp_rises - k0); end
  endtask

  task automatic test_clear();
    press_digit(4, 4, 4);
    press_digit(5, 4, 4);
    checks++;
    if (user_otp !== exp_otp || digit_cnt !== 3'(exp_cnt)) begin
      failures++;
      $display("FAIL clear_pre: got %h/%0d expected %h/%0d", user_otp, digit_cnt, exp_otp, exp_cnt);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    exp_otp = 16'h0;
    exp_cnt = 0;
    checks++;
    if (user_otp !== 16'h0 || digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL clear_result: got %h/%0d expected 0000/0", user_otp, digit_cnt);
    end
  endtask

  task automatic test_clear_on_accept();
    press_digit(2, 4, 4);
    keys = 16'(1) << 10;
    for (int i = 0; i < 6*FRAME && !dut.w_accept; i++) @(negedge clk);
    checks++;
    if (!dut.w_accept) begin
      failures++;
      $display("FAIL clear_accept_timeout: got no accept expected accept of key 9");
    end
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    exp_otp = 16'h0;
    exp_cnt = 0;
    checks++;
    if (user_otp !== 16'h0 || digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL clear_on_accept: got %h/%0d expected 0000/0", user_otp, digit_cnt);
    end
    checks++;
    if (key_pressed !== 1'b1) begin failures++; $display("FAIL clear_on_accept_kp: got %b expected 1", key_pressed); end
    keys = 16'h0;
    repeat (4*FRAME) @(negedge clk);
    checks++;
    if (user_otp !== 16'h0 || digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL clear_on_accept_after: got %h/%0d expected 0000/0", user_otp, digit_cnt);
    end
  endtask

  task automatic test_reset_held();
    int n;
    press_digit(6, 4, 4);
    keys = 16'(1) << 9;
    repeat (FRAME + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (user_otp !== 16'h0 || digit_cnt !== 3'd0 || key_pressed !== 1'b0) begin
      failures++;
      $display("FAIL held_reset_state: got %h/%0d/%b expected 0000/0/0", user_otp, digit_cnt, key_pressed);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_otp = 16'h0;
    exp_cnt = 0;
    n = 0;
    while (!key_pressed && n < 6*FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 31 || n > 35) begin
      failures++;
      $display("FAIL held_accept_latency: got %0d cycles expected 31..35", n);
    end
    model_digit(4'h8);
    checks++;
    if (user_otp !== 16'h0008 || digit_cnt !== 3'd1) begin
      failures++;
      $display("FAIL held_accept_value: got %h/%0d expected 0008/1", user_otp, digit_cnt);
    end
    keys = 16'h0;
    repeat (4*FRAME) @(negedge clk);
  endtask

  task automatic test_random();
    int v0;
    int e0;
    int idx;
    v0 = valid_pulses;
    e0 = exp_valid;
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        exp_otp = 16'h0;
        exp_cnt = 0;
      end else begin
        idx = int'($urandom_range(0, 15));
        press_digit(idx, int'($urandom_range(4, 6)), int'($urandom_range(4, 6)));
      end
      checks++;
      if (user_otp !== exp_otp || digit_cnt !== 3'(exp_cnt)) begin
        failures++;
        $display("FAIL random_step%0d: got %h/%0d expected %h/%0d", t, user_otp, digit_cnt, exp_otp, exp_cnt);
      end
    end
    checks++;
    if (valid_pulses - v0 != exp_valid - e0) begin
      failures++;
      $display("FAIL random_valid_count: got %0d expected %0d", valid_pulses - v0, exp_valid - e0);
    end
  endtask

  task automatic test_valid_shape();
    checks++;
    if (valid_wide != 0) begin failures++; $display("FAIL valid_width: got %0d wide pulses expected 0", valid_wide); end
    checks++;
    if (valid_badcnt != 0) begin failures++; $display("FAIL valid_digit_cnt: got %0d bad pulses expected 0", valid_badcnt); end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    keys      = 16'h0;
    exp_otp   = 16'h0;
    exp_cnt   = 0;
    exp_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_scan();
    test_entry();
    test_new_entry();
    test_bounce();
    test_multi();
    test_clear();
    test_clear_on_accept();
    test_reset_held();
    test_random();
    test_valid_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
